arrayadd_seq: RTL and testbench
===============================

Name: arrayadd_seq

Overview:
- Sequencer for the two-array add datapath.
- On a start command it walks an index range over memory A and memory B, which share one address bus and have synchronous 1-cycle read.
- Each element sum is pushed out on a valid/ready stream, and a running total of the whole range is kept.
- Sits between a host/testbench control port and the paired memories. It replaces the free-running index counter with a bounded, back-pressurable run.

Parameters:
- ADDR_W, 8, index/address width; arrays hold 2**ADDR_W words.
- DATA_W, 32, memory word, element sum and total width.
- OBUF_DEPTH, 2, output buffer entries; minimum 2.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  run request; accepted only in IDLE.
- base  in  ADDR_W  first index of the run; sampled on accepted start.
- len  in  ADDR_W+1  element count, 0..2**ADDR_W; sampled on accepted start.
- busy  out  1  high from the cycle after start acceptance until done.
- done  out  1  one-cycle pulse at end of run.
- mem_addr  out  ADDR_W  shared read address for A and B.
- mem_en  out  1  read strobe; data returns next cycle.
- rd_a  in  DATA_W  memory A read data, valid the cycle after mem_en.
- rd_b  in  DATA_W  memory B read data, valid the cycle after mem_en.
- out_valid  out  1  element result available.
- out_ready  in  1  consumer accepts when out_valid and out_ready are both high.
- out_index  out  ADDR_W  index of the presented element.
- out_data  out  DATA_W  rd_a+rd_b mod 2**DATA_W; carry dropped.
- total  out  DATA_W  sum of all element results issued this run, mod 2**DATA_W.
- total_ovf  out  1  sticky: some accumulation into total carried out.

Behaviour:
- Reset: state IDLE; busy, done, mem_en, out_valid, total_ovf = 0; total = 0; mem_addr = 0.
  - Output buffer emptied. In-flight read data discarded: the return-cycle capture is masked in the cycle after reset.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - start=1 latches base and len, clears total and total_ovf.
  - len=0 goes to DONE; otherwise goes to ISSUE.
  - start in any other state is ignored.
- ISSUE:
  - mem_en=1 when credit>0, where credit = OBUF_DEPTH − occupancy − in_flight + (1 if a pop occurs this cycle).
  - mem_addr = base + issued count, wrapping mod 2**ADDR_W.
  - After len issues, go to DRAIN.
- Data return (cycle after mem_en):
  - Element sum written to the buffer with its index.
  - total += element sum at the same edge; a carry-out sets total_ovf.
- Output:
  - Buffer is FIFO; out_* driven from the head entry.
  - out_index/out_data stay stable while out_valid=1 and out_ready=0.
- DRAIN: wait until in_flight=0 and buffer empty, then go to DONE.
- DONE: done=1 for one cycle, then IDLE. total and total_ovf hold until the next accepted start.
- Latency, start sampled at edge k:
  - mem_en high in cycle k+1.
  - First out_valid in cycle k+3.
  - With out_ready held high: one result per cycle; done pulse one cycle after the last handshake.
- Back-pressure: with out_ready=0, exactly OBUF_DEPTH reads are issued, then mem_en stays 0. No data is ever lost or overwritten.
- Wrap: base=0xFE, len=4 yields indices FE, FF, 00, 01.
- len = 2**ADDR_W covers every index exactly once.
- Synchronous rst mid-run returns to IDLE at that edge.
  - No done pulse.
  - Buffered results are dropped.
  - total and total_ovf are cleared.

Decomposition:
- Shared package arrayadd_pkg:
  - ADDR_W and DATA_W defaults.
  - FSM state encoding (IDLE=0, ISSUE=1, DRAIN=2, DONE=3).
  - Output entry struct/concat layout {index, data}.
- Sub-module arrayadd_obuf: OBUF_DEPTH-entry synchronous FIFO.
  - Ports: push, push_data, pop, head, occupancy, empty.
  - Simultaneous push+pop on a full buffer is legal; occupancy is unchanged.
- Credit logic and FSM live in arrayadd_seq.

Test Plan:
- Memories A[i]=i, B[i]=0x100*i; start base=0, len=4, out_ready=1 → out_data 0x0,0x101,0x202,0x303 with indices 0..3 on consecutive cycles; first out_valid 3 cycles after start; total=0x606; done pulse once; total_ovf=0.
- base=0xFE, len=4 → out_index FE,FF,00,01 in order.
- out_ready=0 for 10 cycles after start with len=8 → exactly 2 mem_en pulses and head value stable. Then out_ready=1 → remaining 6 delivered, 8 in total, none duplicated.
- A[0..1]=0xFFFFFFFF, B[0..1]=1, len=2 → each element 0x00000000, total=0, total_ovf=0. Then A[0..1]=0x80000000, B=0 → total=0, total_ovf=1.
- len=0 → done pulses 2 cycles after start, mem_en never asserted, out_valid stays 0.
- rst asserted 2 cycles into a len=16 run → next cycle busy=0, out_valid=0, total=0. A fresh start then behaves as in scenario 1.

Source files
------------

// File: rtl/arrayadd_pkg.sv
// Shared definitions for the two-array add sequencer and its output buffer.
package arrayadd_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 32;

    // Sequencer states; encoding is fixed so that debug probes read stable codes.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Output buffer entry at the default widths: {index, data}, index in the upper bits.
    // Parameterised instances use the same {index, data} concatenation order.
    typedef struct packed {
        logic [ADDR_W_DEF-1:0] index;
        logic [DATA_W_DEF-1:0] data;
    } entry_t;

endpackage

// File: rtl/arrayadd_obuf.sv
// Small synchronous FIFO holding finished element results until the consumer takes them.
module arrayadd_obuf #(
    parameter int WIDTH = 40,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             head,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy,
    output logic                         empty
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] slots [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Pointers wrap at DEPTH, which need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty   = (occupancy == '0);
    assign do_pop  = pop && !empty;
    // A push into a full buffer is only taken when a pop frees the head slot at the same edge.
    assign do_push = push && ((occupancy != CNT_W'(DEPTH)) || do_pop);
    assign head    = slots[rd_ptr];

    // Pointer and occupancy bookkeeping; the only state cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   occupancy <= occupancy + CNT_W'(1);
                2'b01:   occupancy <= occupancy - CNT_W'(1);
                default: occupancy <= occupancy;
            endcase
        end
    end

    // Entry storage; contents are meaningless while the slot is not occupied.
    always_ff @(posedge clk) begin
        if (do_push) slots[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/arrayadd_seq.sv
// Bounded, back-pressurable sequencer: reads A[i] and B[i] over a shared address bus,
// streams A[i]+B[i] out on valid/ready and keeps a running total for the run.
module arrayadd_seq import arrayadd_pkg::*; #(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int OBUF_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W:0]   len,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_en,
    input  logic [DATA_W-1:0] rd_a,
    input  logic [DATA_W-1:0] rd_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_index,
    output logic [DATA_W-1:0] out_data,
    output logic [DATA_W-1:0] total,
    output logic              total_ovf
);
    localparam int OCC_W = $clog2(OBUF_DEPTH + 1);
    localparam int ENT_W = ADDR_W + DATA_W;

    state_t              state;
    state_t              state_nxt;
    logic [ADDR_W-1:0]   base_q;
    logic [ADDR_W:0]     len_q;
    logic [ADDR_W:0]     issued;
    logic                vld_p1;
    logic [ADDR_W-1:0]   idx_p1;
    logic [DATA_W-1:0]   elem_sum;
    logic [DATA_W:0]     total_sum;
    logic [ENT_W-1:0]    head;
    logic [OCC_W-1:0]    occupancy;
    logic                empty;
    logic                pop;
    logic                last_issue;

    // Element sum: carry out of the word is dropped.
    function automatic logic [DATA_W-1:0] wrap_add(input logic [DATA_W-1:0] x,
                                                    input logic [DATA_W-1:0] y);
        return x + y;
    endfunction

    // Accumulation keeping the carry bit so the sticky overflow flag can see it.
    function automatic logic [DATA_W:0] acc_add(input logic [DATA_W-1:0] acc,
                                                 input logic [DATA_W-1:0] x);
        return {1'b0, acc} + {1'b0, x};
    endfunction

    assign out_valid  = !empty;
    assign pop        = out_valid && out_ready;
    assign out_index  = head[ENT_W-1 -: ADDR_W];
    assign out_data   = head[DATA_W-1:0];
    assign mem_addr   = base_q + issued[ADDR_W-1:0];
    assign last_issue = ((issued + (ADDR_W+1)'(1)) == len_q);
    assign elem_sum   = wrap_add(rd_a, rd_b);
    assign total_sum  = acc_add(total, elem_sum);

    // Issue a read only when a buffer slot is guaranteed for its result, counting the
    // read already in flight and any slot freed by a pop at this same edge.
    assign mem_en = (state == ST_ISSUE) && (issued != len_q) &&
                    ((int'(occupancy) + int'(vld_p1)) < (OBUF_DEPTH + int'(pop)));

    // Next-state and status decode.
    always_comb begin
        state_nxt = state;
        done      = 1'b0;
        busy      = (state != ST_IDLE);
        case (state)
            ST_IDLE: begin
                if (start) state_nxt = (len == '0) ? ST_DONE : ST_ISSUE;
            end
            ST_ISSUE: begin
                if (mem_en && last_issue) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                // Leave as soon as the final result is being taken so done follows the last handshake.
                if (!vld_p1 && (empty || ((occupancy == OCC_W'(1)) && pop))) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Control state, run bounds, issue count, read-return valid and running total.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            base_q    <= '0;
            len_q     <= '0;
            issued    <= '0;
            vld_p1    <= 1'b0;
            total     <= '0;
            total_ovf <= 1'b0;
        end else begin
            state  <= state_nxt;
            vld_p1 <= mem_en;
            if ((state == ST_IDLE) && start) begin
                base_q    <= base;
                len_q     <= len;
                issued    <= '0;
                total     <= '0;
                total_ovf <= 1'b0;
            end else begin
                if (mem_en) issued <= issued + (ADDR_W+1)'(1);
                if (vld_p1) begin
                    total <= total_sum[DATA_W-1:0];
                    if (total_sum[DATA_W]) total_ovf <= 1'b1;
                end
            end
        end
    end

    // p0 -> p1: remember which index the outstanding read belongs to.
    always_ff @(posedge clk) begin
        idx_p1 <= mem_addr;
    end

    arrayadd_obuf #(
        .WIDTH (ENT_W),
        .DEPTH (OBUF_DEPTH)
    ) u_obuf (
        .clk       (clk),
        .rst       (rst),
        .push      (vld_p1),
        .push_data ({idx_p1, elem_sum}),
        .pop       (pop),
        .head      (head),
        .occupancy (occupancy),
        .empty     (empty)
    );

endmodule

// File: tb/tb_arrayadd_seq.sv
// Bench for arrayadd_seq: table-driven runs, randomized runs against a reference model,
// and hand-written back-pressure, overflow, empty-run and mid-run reset sequences.
module tb_arrayadd_seq;
    localparam int AW = 8;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] base = '0;
    logic [AW:0]   len = '0;
    logic          busy, done, mem_en, out_valid, total_ovf;
    logic          out_ready = 1'b0;
    logic [AW-1:0] mem_addr, out_index;
    logic [DW-1:0] rd_a = '0, rd_b = '0, out_data, total;

    logic [DW-1:0] mem_a [256];
    logic [DW-1:0] mem_b [256];

    typedef struct {
        logic [AW-1:0] base;
        logic [AW:0]   len;
        logic [DW-1:0] exp_total;
        logic          exp_ovf;
        logic [AW-1:0] exp_last_idx;
    } vec_t;
    vec_t tv [5];

    int nvec = 0;
    int nerr = 0;
    int cyc = 0;
    int start_cyc = 0;

    // Monitor state
    logic [AW-1:0] got_idx [$];
    logic [DW-1:0] got_dat [$];
    int en_cnt = 0, done_cnt = 0, done_cyc = -1, first_vld_cyc = -1, last_hs_cyc = -1;

    always #5 clk = ~clk;

    arrayadd_seq #(.ADDR_W(AW), .DATA_W(DW), .OBUF_DEPTH(2)) dut (
        .clk(clk), .rst(rst), .start(start), .base(base), .len(len),
        .busy(busy), .done(done), .mem_addr(mem_addr), .mem_en(mem_en),
        .rd_a(rd_a), .rd_b(rd_b), .out_valid(out_valid), .out_ready(out_ready),
        .out_index(out_index), .out_data(out_data), .total(total), .total_ovf(total_ovf)
    );

    // Paired memories with one-cycle synchronous read.
    always @(posedge clk) begin
        if (mem_en) begin
            rd_a <= mem_a[mem_addr];
            rd_b <= mem_b[mem_addr];
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Observe the DUT mid-cycle.
    always @(negedge clk) begin
        if (mem_en) en_cnt++;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (out_valid && first_vld_cyc < 0) first_vld_cyc = cyc;
        if (out_valid && out_ready) begin
            got_idx.push_back(out_index);
            got_dat.push_back(out_data);
            last_hs_cyc = cyc;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_mon();
        got_idx.delete();
        got_dat.delete();
        en_cnt = 0; done_cnt = 0; done_cyc = -1; first_vld_cyc = -1; last_hs_cyc = -1;
    endtask

    task automatic fill_ramp();
        for (int i = 0; i < 256; i++) begin
            mem_a[i] = DW'(i);
            mem_b[i] = DW'(i) << 8;
        end
    endtask

    task automatic do_start(input logic [AW-1:0] b, input logic [AW:0] n);
        @(posedge clk); #1;
        clear_mon();
        start = 1'b1; base = b; len = n;
        @(posedge clk); #1;
        start = 1'b0;
        start_cyc = cyc;
    endtask

    task automatic wait_done(input int budget, input bit rand_rdy);
        int k = 0;
        while (done_cnt == 0 && k < budget) begin
            @(posedge clk); #1;
            if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
            k++;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("done_pulses", 64'(done_cnt), 64'd1);
    endtask

    // Reference: the run visits (b+i) mod 256; each result is A+B mod 2^32; total is the
    // wrapped sum of all results and overflow records any carry out of that sum.
    task automatic check_run(input logic [AW-1:0] b, input int n, input string tag);
        logic [DW-1:0] tot = '0;
        logic          ovf = 1'b0;
        logic [63:0]   wide;
        logic [AW-1:0] idx;
        logic [DW-1:0] s;
        chk({tag, "_count"}, 64'(got_idx.size()), 64'(n));
        for (int i = 0; i < n; i++) begin
            idx  = b + AW'(i);
            s    = mem_a[idx] + mem_b[idx];
            wide = 64'(tot) + 64'(s);
            if (wide > 64'hFFFF_FFFF) ovf = 1'b1;
            tot = wide[31:0];
            if (i < got_idx.size()) begin
                chk({tag, "_index"}, 64'(got_idx[i]), 64'(idx));
                chk({tag, "_data"}, 64'(got_dat[i]), 64'(s));
            end
        end
        chk({tag, "_total"}, 64'(total), 64'(tot));
        chk({tag, "_ovf"}, 64'(total_ovf), 64'(ovf));
    endtask

    task automatic run_vec(input int v);
        fill_ramp();
        out_ready = 1'b1;
        do_start(tv[v].base, tv[v].len);
        chk("mem_en_first", 64'(mem_en), 64'd1);
        chk("busy_run", 64'(busy), 64'd1);
        wait_done(700, 1'b0);
        chk("first_valid_latency", 64'(first_vld_cyc - start_cyc), 64'd2);
        chk("done_after_last_hs", 64'(done_cyc - last_hs_cyc), 64'd1);
        if (got_idx.size() > 0) chk("last_index", 64'(got_idx[$]), 64'(tv[v].exp_last_idx));
        chk("vec_total", 64'(total), 64'(tv[v].exp_total));
        chk("vec_ovf", 64'(total_ovf), 64'(tv[v].exp_ovf));
        check_run(tv[v].base, int'(tv[v].len), "vec");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected run to finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tv[0] = '{base: 8'h00, len: 9'd4,   exp_total: 32'h0000_0606, exp_ovf: 1'b0, exp_last_idx: 8'h03};
        tv[1] = '{base: 8'hFE, len: 9'd4,   exp_total: 32'h0001_FFFE, exp_ovf: 1'b0, exp_last_idx: 8'h01};
        tv[2] = '{base: 8'h10, len: 9'd3,   exp_total: 32'h0000_3333, exp_ovf: 1'b0, exp_last_idx: 8'h12};
        tv[3] = '{base: 8'h80, len: 9'd256, exp_total: 32'h007F_FF80, exp_ovf: 1'b0, exp_last_idx: 8'h7F};
        tv[4] = '{base: 8'hFF, len: 9'd1,   exp_total: 32'h0000_FFFF, exp_ovf: 1'b0, exp_last_idx: 8'hFF};
        fill_ramp();

        // Reset state
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_mem_en", 64'(mem_en), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_total", 64'(total), 64'd0);
        chk("rst_ovf", 64'(total_ovf), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);

        // Table-driven runs with the consumer always ready
        for (int v = 0; v < 5; v++) run_vec(v);

        // Back-pressure: two reads fill the buffer, then issue stalls with the head held
        fill_ramp();
        out_ready = 1'b0;
        do_start(8'h05, 9'd8);
        repeat (4) @(posedge clk);
        #1;
        chk("bp_head_idx_early", 64'(out_index), 64'h05);
        chk("bp_head_dat_early", 64'(out_data), 64'h505);
        repeat (6) @(posedge clk);
        #1;
        chk("bp_mem_en_count", 64'(en_cnt), 64'd2);
        chk("bp_valid", 64'(out_valid), 64'd1);
        chk("bp_head_idx", 64'(out_index), 64'h05);
        chk("bp_head_dat", 64'(out_data), 64'h505);
        out_ready = 1'b1;
        wait_done(200, 1'b0);
        check_run(8'h05, 8, "bp");

        // Element wrap with no total carry, then total carry with no element wrap
        mem_a[0] = 32'hFFFF_FFFF; mem_a[1] = 32'hFFFF_FFFF;
        mem_b[0] = 32'h1;         mem_b[1] = 32'h1;
        do_start(8'h00, 9'd2);
        wait_done(100, 1'b0);
        chk("wrap_elem0", 64'(got_dat.size() > 0 ? got_dat[0] : 32'hDEAD), 64'd0);
        chk("wrap_total", 64'(total), 64'd0);
        chk("wrap_ovf", 64'(total_ovf), 64'd0);
        mem_a[0] = 32'h8000_0000; mem_a[1] = 32'h8000_0000;
        mem_b[0] = 32'h0;         mem_b[1] = 32'h0;
        do_start(8'h00, 9'd2);
        wait_done(100, 1'b0);
        chk("carry_total", 64'(total), 64'd0);
        chk("carry_ovf", 64'(total_ovf), 64'd1);
        check_run(8'h00, 2, "carry");

        // Empty run: done without any read or result
        do_start(8'h33, 9'd0);
        wait_done(4, 1'b0);
        chk("len0_mem_en", 64'(en_cnt), 64'd0);
        chk("len0_no_valid", 64'(first_vld_cyc), 64'hFFFF_FFFF_FFFF_FFFF);
        chk("len0_done_within_2", 64'(done_cyc - start_cyc <= 1), 64'd1);

        // Randomized runs against the reference model
        for (int r = 0; r < 6; r++) begin
            logic [AW-1:0] rb;
            int rn;
            for (int i = 0; i < 256; i++) begin
                mem_a[i] = $urandom;
                mem_b[i] = (r % 2 == 0) ? $urandom : (32'hF000_0000 | $urandom);
            end
            rb = AW'($urandom);
            rn = $urandom_range(1, 40);
            out_ready = 1'($urandom_range(0, 1));
            do_start(rb, (AW+1)'(rn));
            wait_done(2000, 1'b1);
            check_run(rb, rn, "rand");
        end

        // Reset in the middle of a run
        fill_ramp();
        out_ready = 1'b1;
        do_start(8'h00, 9'd16);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_valid", 64'(out_valid), 64'd0);
        chk("midrst_total", 64'(total), 64'd0);
        chk("midrst_ovf", 64'(total_ovf), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("midrst_still_idle", 64'(out_valid | busy | mem_en), 64'd0);
        chk("midrst_no_done", 64'(done_cnt), 64'd0);
        run_vec(0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
